n_bin_accumulator: RTL and testbench
====================================

N_BIN_ACCUMULATOR -- requirements
Module: n_bin_accumulator

Interface
REQ-001 SHALL have parameter N, default 16: input sample width, unsigned magnitude.
REQ-002 SHALL have parameter BINS, default 4: bins captured per frame, range 1..64.
REQ-003 SHALL have parameter SUM_WIDTH, default 24: accumulator and output width, at least N.
REQ-004 SHALL have parameter FFT_LEN, default 1024: samples per frame, a power of 2, at least BINS.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port areset_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port in_data, input, N: FFT bin magnitude.
REQ-008 SHALL have port fft_valid, input, 1: in_data is valid this cycle.
REQ-009 SHALL have port fft_sof, input, 1: first sample of a frame; meaningful only with fft_valid.
REQ-010 SHALL have port bin_offset, input, clog2(FFT_LEN): index of the first captured bin.
REQ-011 SHALL have port avg_log2, input, 4: number of frames integrated is 2^avg_log2, range 0..15.
REQ-012 SHALL have port out_data, output, [BINS-1:0][SUM_WIDTH-1:0]: integrated bins; element k is bin bin_offset+k.
REQ-013 SHALL have port out_valid, output, 1: out_data holds a result.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts out_data.
REQ-015 SHALL have port overrun, output, 1: sticky flag, set when a result is dropped.
REQ-016 SHALL have port frame_err, output, 1: sticky flag, set when a short frame is seen.

Function
REQ-017 SHALL use states IDLE, COLLECT and SKIP.
- IDLE -> COLLECT on fft_valid&&fft_sof.
- COLLECT -> SKIP after bin index bin_offset+BINS-1 is accepted.
- SKIP -> COLLECT on the next fft_valid&&fft_sof.
REQ-018 SHALL keep a sample index that is 0 at sof and advances only on fft_valid; cycles with fft_valid=0 are stalls and are ignored.
REQ-019 SHALL latch bin_offset and avg_log2 at the sof that opens an integration window; changes mid-window have no effect until the next window.
REQ-020 SHALL clamp a latched bin_offset above FFT_LEN-BINS to FFT_LEN-BINS.
REQ-021 SHALL, in COLLECT, add each sample with index bin_offset+k to accumulator k, zero-extended to SUM_WIDTH.
REQ-022 SHALL saturate every add at 2^SUM_WIDTH-1; accumulators never wrap.
REQ-023 SHALL clear the accumulators on the sof that opens a window, so the first frame's samples load rather than add.
REQ-024 SHALL count a frame as complete when bin bin_offset+BINS-1 is accepted; the window closes after 2^avg_log2 complete frames.
REQ-025 SHALL treat fft_sof during COLLECT, before the last captured bin, as a short frame:
- sets frame_err;
- partial contributions are kept;
- the frame is not counted;
- a new frame starts at index 0.
REQ-026 SHALL, in SKIP, ignore samples with index at or above FFT_LEN until the next sof.
REQ-027 SHALL double-buffer the result: on window close, the accumulators copy to the output register and out_valid rises the cycle after the final contributing sample is accepted.
REQ-028 SHALL hold out_data stable while out_valid=1 and out_ready=0; out_valid falls the cycle after out_valid&&out_ready.
REQ-029 SHALL, when a window closes while out_valid=1 and out_ready=0:
- drop the new result;
- set overrun;
- leave the held out_data unchanged.
REQ-030 SHALL, when a window closes in the same cycle as a handshake, load the new result and keep out_valid=1 with no overrun.
REQ-031 SHALL let accumulation continue in all output states; the next window opens on the next sof after close.

Reset
REQ-032 SHALL, on areset_n=0, asynchronously set:
- state IDLE;
- out_data all 0;
- accumulators and counters 0;
- out_valid=0, overrun=0, frame_err=0.
REQ-033 SHALL discard a window in progress on reset; the first sof after release opens a fresh window.
REQ-034 SHALL keep overrun and frame_err set until reset.

Verification
REQ-035 SHALL check: N=16, BINS=4, avg_log2=0, bin_offset=0, one ramp frame 0..1023, out_ready=1 -> out_data {3,2,1,0}, out_valid high for one cycle.
REQ-036 SHALL check: avg_log2=2, bin_offset=10, four ramp frames with random fft_valid gaps -> out_data {52,48,44,40}.
REQ-037 SHALL check: SUM_WIDTH=17, all samples 0xFFFF -> avg_log2=1 gives 0x1FFFE in each bin; avg_log2=2 gives 0x1FFFF (saturated).
REQ-038 SHALL check: out_ready=0 across two completed windows -> the first result is held, overrun=1; then out_ready=1 -> first result accepted, out_valid=0.
REQ-039 SHALL check: sof at index 2 with bin_offset=0 -> frame_err=1 and the frame count is not incremented.
REQ-040 SHALL check: reset asserted mid-COLLECT -> all outputs 0 immediately; after release, a clean avg_log2=0 ramp frame gives {3,2,1,0}.

Source files
------------

// File: rtl/n_bin_accumulator.sv
// Integrates BINS consecutive FFT bin magnitudes over 2^avg_log2 frames with saturating sums.
// Result is double-buffered behind a valid/ready register; a result closing while one is held is dropped.
module n_bin_accumulator #(
  parameter int N         = 16,
  parameter int BINS      = 4,
  parameter int SUM_WIDTH = 24,
  parameter int FFT_LEN   = 1024
) (
  input  logic                            clk,
  input  logic                            areset_n,
  input  logic [N-1:0]                    in_data,
  input  logic                            fft_valid,
  input  logic                            fft_sof,
  input  logic [$clog2(FFT_LEN)-1:0]      bin_offset,
  input  logic [3:0]                      avg_log2,
  output logic [BINS-1:0][SUM_WIDTH-1:0]  out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            overrun,
  output logic                            frame_err
);
  localparam int OW = $clog2(FFT_LEN);
  localparam int IW = OW + 1;
  localparam logic [IW-1:0] MAX_OFF = IW'(FFT_LEN - BINS);
  localparam logic [IW-1:0] LEN_I   = IW'(FFT_LEN);

  typedef enum logic [1:0] {IDLE, COLLECT, SKIP} state_t;

  state_t                         state;
  logic [IW-1:0]                  idx;
  logic [IW-1:0]                  off_q;
  logic [3:0]                     avg_q;
  logic [15:0]                    frm_cnt;
  logic [BINS-1:0][SUM_WIDTH-1:0] acc;
  logic [BINS-1:0][SUM_WIDTH-1:0] acc_nxt;

  logic          open_win, capture, hit, last, close;
  logic [IW-1:0] off_in, eff_off, cur_idx, rel, idx_nxt;
  logic [3:0]    eff_avg;
  logic [15:0]   cnt_base, cnt_inc;

  function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] a,
                                                   input logic [N-1:0] b);
    logic [SUM_WIDTH:0] s;
    s = {1'b0, a} + (SUM_WIDTH+1)'(b);
    return s[SUM_WIDTH] ? '1 : s[SUM_WIDTH-1:0];
  endfunction

  assign off_in = ({1'b0, bin_offset} > MAX_OFF) ? MAX_OFF : {1'b0, bin_offset};

  // The sof sample itself is index 0; the window-opening sof uses the live parameters
  // and a cleared accumulator base so its contribution loads rather than adds.
  always_comb begin
    open_win = fft_valid && fft_sof && (state == IDLE);
    eff_off  = open_win ? off_in : off_q;
    eff_avg  = open_win ? avg_log2 : avg_q;
    capture  = fft_valid && (fft_sof || (state == COLLECT));
    cur_idx  = fft_sof ? '0 : idx;
    rel      = cur_idx - eff_off;
    hit      = capture && (cur_idx >= eff_off) && (cur_idx < eff_off + IW'(BINS));
    last     = hit && (rel == IW'(BINS - 1));
    cnt_base = open_win ? '0 : frm_cnt;
    cnt_inc  = cnt_base + 16'd1;
    close    = last && (cnt_inc == (16'd1 << eff_avg));
    idx_nxt  = (cur_idx >= LEN_I) ? LEN_I : cur_idx + IW'(1);
    for (int k = 0; k < BINS; k++) begin
      acc_nxt[k] = open_win ? '0 : acc[k];
      if (hit && (rel == IW'(k))) acc_nxt[k] = sat_add(acc_nxt[k], in_data);
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= IDLE;
      idx       <= '0;
      off_q     <= '0;
      avg_q     <= '0;
      frm_cnt   <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (fft_valid) idx <= idx_nxt;
      if (open_win) begin
        off_q <= off_in;
        avg_q <= avg_log2;
      end
      if (capture) begin
        acc     <= acc_nxt;
        frm_cnt <= close ? '0 : (last ? cnt_inc : cnt_base);
      end

      if (close)        state <= IDLE;
      else if (last)    state <= SKIP;
      else if (capture) state <= COLLECT;

      // A sof while still collecting means the previous frame was short.
      if (fft_valid && fft_sof && (state == COLLECT)) frame_err <= 1'b1;

      if (close && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (close) begin
        out_data  <= acc_nxt;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_n_bin_accumulator.sv
// Bench for n_bin_accumulator: vector table of integration windows plus hand-built corner sequences.
module tb_n_bin_accumulator;
  localparam int N = 16, BINS = 4, SW = 17, FL = 1024;
  typedef logic [BINS-1:0][SW-1:0] res_t;
  typedef struct {
    int   avg;
    int   off;
    int   nfr;
    int   len;
    bit   ones;
    int   gap;
    res_t exp;
  } vec_t;

  logic                clk = 1'b0;
  logic                areset_n = 1'b0;
  logic [N-1:0]        in_data;
  logic                fft_valid;
  logic                fft_sof;
  logic [9:0]          bin_offset;
  logic [3:0]          avg_log2;
  res_t                out_data;
  logic                out_valid;
  logic                out_ready;
  logic                overrun;
  logic                frame_err;

  int   n_checks = 0;
  int   n_err = 0;
  int   vld_total = 0;
  int   vld_base;
  res_t sb[$];
  res_t mon_exp;
  vec_t vecs[7];

  always #5 clk = ~clk;

  n_bin_accumulator #(.N(N), .BINS(BINS), .SUM_WIDTH(SW), .FFT_LEN(FL)) dut (
    .clk(clk), .areset_n(areset_n), .in_data(in_data), .fft_valid(fft_valid),
    .fft_sof(fft_sof), .bin_offset(bin_offset), .avg_log2(avg_log2),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .frame_err(frame_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every accepted output is compared to the oldest expected result.
  always @(negedge clk) begin
    if (out_valid) vld_total++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_result: got %0h, expected no result", out_data);
      end else begin
        mon_exp = sb.pop_front();
        chk("result", out_data, mon_exp);
      end
    end
  end

  task automatic drive(input bit v, input bit s, input logic [N-1:0] d);
    @(posedge clk);
    #1;
    fft_valid = v;
    fft_sof   = s;
    in_data   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  task automatic send_frame(input int len, input bit ones, input int gap);
    for (int i = 0; i < len; i++) begin
      if (gap > 0) repeat ($urandom_range(gap, 0)) drive(1'b0, 1'($urandom), 16'($urandom));
      drive(1'b1, i == 0, ones ? 16'hFFFF : 16'(i));
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d results pending after %0d cycles, required 0", name, sb.size(), n);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_data = '0; fft_valid = 1'b0; fft_sof = 1'b0;
    bin_offset = '0; avg_log2 = '0; out_ready = 1'b1;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_frame_err", frame_err, 0);
    #10 areset_n = 1'b1;

    vecs[0] = '{0, 0,    1, 1024, 0, 0, {17'd3, 17'd2, 17'd1, 17'd0}};
    vecs[1] = '{2, 10,   4, 1024, 0, 3, {17'd52, 17'd48, 17'd44, 17'd40}};
    vecs[2] = '{1, 0,    2, 64,   1, 2, {4{17'h1FFFE}}};
    vecs[3] = '{2, 0,    4, 64,   1, 2, {4{17'h1FFFF}}};
    vecs[4] = '{0, 1020, 1, 1024, 0, 0, {17'd1023, 17'd1022, 17'd1021, 17'd1020}};
    vecs[5] = '{0, 1023, 1, 1024, 0, 1, {17'd1023, 17'd1022, 17'd1021, 17'd1020}};
    vecs[6] = '{3, 5,    8, 32,   0, 1, {17'd64, 17'd56, 17'd48, 17'd40}};

    // Parameters are scrambled after every frame; only the window-opening values may count.
    foreach (vecs[v]) begin
      bin_offset = 10'(vecs[v].off);
      avg_log2   = 4'(vecs[v].avg);
      sb.push_back(vecs[v].exp);
      vld_base = vld_total;
      for (int f = 0; f < vecs[v].nfr; f++) begin
        send_frame(vecs[v].len, vecs[v].ones, vecs[v].gap);
        bin_offset = 10'($urandom);
        avg_log2   = 4'($urandom);
      end
      idle(4);
      wait_drain($sformatf("vec%0d_drain", v));
      chk($sformatf("vec%0d_valid_cycles", v), vld_total - vld_base, 1);
    end

    // Window closes in the same cycle the held result is accepted.
    out_ready = 1'b0; bin_offset = '0; avg_log2 = '0;
    sb.push_back({17'd3, 17'd2, 17'd1, 17'd0});
    send_frame(8, 1'b0, 0);
    idle(3);
    chk("held_valid", out_valid, 1);
    bin_offset = 10'd4;
    sb.push_back({17'd7, 17'd6, 17'd5, 17'd4});
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, 16'(i));
      if (i == 7) out_ready = 1'b1;
    end
    idle(3);
    wait_drain("close_with_handshake");
    chk("no_overrun_on_handshake", overrun, 0);
    chk("valid_low_after_handshake", out_valid, 0);

    // Second window completes while the first result is still held.
    out_ready = 1'b0; bin_offset = '0;
    sb.push_back({17'd3, 17'd2, 17'd1, 17'd0});
    send_frame(8, 1'b0, 0);
    bin_offset = 10'd8;
    send_frame(16, 1'b0, 0);
    idle(3);
    chk("overrun_set", overrun, 1);
    chk("overrun_valid_held", out_valid, 1);
    chk("overrun_data_held", out_data, {17'd3, 17'd2, 17'd1, 17'd0});
    out_ready = 1'b1;
    wait_drain("overrun_drain");
    idle(2);
    chk("overrun_valid_low", out_valid, 0);
    chk("overrun_sticky", overrun, 1);

    // Short frame: sof at index 2 keeps partial sums but does not count the frame.
    chk("frame_err_clear", frame_err, 0);
    avg_log2 = 4'd1; bin_offset = '0;
    sb.push_back({17'd6, 17'd4, 17'd202, 17'd100});
    drive(1'b1, 1'b1, 16'd100);
    drive(1'b1, 1'b0, 16'd200);
    send_frame(8, 1'b0, 0);
    idle(3);
    chk("frame_err_set", frame_err, 1);
    chk("short_frame_not_counted", out_valid, 0);
    send_frame(8, 1'b0, 0);
    idle(3);
    wait_drain("short_frame_drain");

    // Reset in the middle of a window with a result held.
    out_ready = 1'b0; avg_log2 = '0; bin_offset = '0;
    send_frame(8, 1'b0, 0);
    idle(2);
    chk("pre_reset_valid", out_valid, 1);
    avg_log2 = 4'd3;
    drive(1'b1, 1'b1, 16'd9);
    drive(1'b1, 1'b0, 16'd9);
    drive(1'b1, 1'b0, 16'd9);
    #2 areset_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_data", out_data, 0);
    chk("midreset_overrun", overrun, 0);
    chk("midreset_frame_err", frame_err, 0);
    idle(2);
    areset_n = 1'b1;
    out_ready = 1'b1; avg_log2 = '0;
    sb.push_back({17'd3, 17'd2, 17'd1, 17'd0});
    send_frame(8, 1'b0, 0);
    idle(3);
    wait_drain("post_reset_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
